// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite types, widths, channel payloads and the byte-lane merge helper.
package axi4_lite_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
    } aw_beat_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } w_beat_t;

    // Replace only the byte lanes whose strobe bit is set.
    function automatic logic [DATA_W-1:0] strb_merge(
        input logic [DATA_W-1:0] old,
        input logic [DATA_W-1:0] wdata,
        input logic [STRB_W-1:0] wstrb
    );
        logic [DATA_W-1:0] merged;
        merged = old;
        for (int i = 0; i < int'(STRB_W); i++) begin
            if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_slot.sv
// One-entry holding slot: captures a beat when empty, holds it until popped.
module axi4_lite_slot #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready_c,
    output logic         full,
    output logic [W-1:0] data,
    input  logic         pop
);

    assign in_ready_c = ~full;

    // Fill and pop are mutually exclusive: fill needs empty, pop needs full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 1'b0;
            data <= '0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
            data <= in_data;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite register bank responder with independent AW/W slots and local register taps.
module axi4_lite_reg_slave
    import axi4_lite_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [31:0]                AWADDR,
    input  logic [3:0]                 AWCACHE,
    input  logic [2:0]                 AWPROT,
    input  logic                       AWVALID,
    output logic                       AWREADY,
    input  logic [31:0]                WDATA,
    input  logic [3:0]                 WSTRB,
    input  logic                       WVALID,
    output logic                       WREADY,
    output logic                       BVALID,
    input  logic                       BREADY,
    output logic [1:0]                 BRESP,
    input  logic [31:0]                ARADDR,
    input  logic [3:0]                 ARCACHE,
    input  logic [2:0]                 ARPROT,
    input  logic                       ARVALID,
    output logic                       ARREADY,
    output logic [31:0]                RDATA,
    output logic [1:0]                 RRESP,
    output logic                       RVALID,
    input  logic                       RREADY,
    output logic [NUM_REGS*32-1:0]     reg_q,
    output logic [NUM_REGS-1:0]        wr_pulse
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    aw_beat_t          aw_in, aw_q;
    w_beat_t           w_in, w_q;
    logic              aw_full, w_full, commit;
    logic              wr_ok, rd_ok;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              unused_bits;

    assign aw_in = '{addr: AWADDR};
    assign w_in  = '{data: WDATA, strb: WSTRB};

    axi4_lite_slot #(.W($bits(aw_beat_t))) u_aw_slot (
        .clk(ACLK), .rst(ARESET), .in_data(aw_in), .in_valid(AWVALID),
        .in_ready_c(AWREADY), .full(aw_full), .data(aw_q), .pop(commit)
    );

    axi4_lite_slot #(.W($bits(w_beat_t))) u_w_slot (
        .clk(ACLK), .rst(ARESET), .in_data(w_in), .in_valid(WVALID),
        .in_ready_c(WREADY), .full(w_full), .data(w_q), .pop(commit)
    );

    // Decode: in range only when every bit above the register index is zero.
    assign wr_idx = aw_q.addr[2 +: IDX_W];
    assign rd_idx = ARADDR[2 +: IDX_W];
    assign wr_ok  = (aw_q.addr[ADDR_W-1:IDX_W+2] == '0);
    assign rd_ok  = (ARADDR[ADDR_W-1:IDX_W+2] == '0);
    assign commit = aw_full & w_full & (~BVALID | BREADY);
    assign ARREADY = ~RVALID;

    assign unused_bits = ^{AWCACHE, AWPROT, ARCACHE, ARPROT, aw_q.addr[1:0], ARADDR[1:0]};

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int k = 0; k < int'(NUM_REGS); k++) regs[k] <= RESET_VAL;
        end else if (commit && wr_ok) begin
            regs[wr_idx] <= strb_merge(regs[wr_idx], w_q.data, w_q.strb);
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wr_pulse <= '0;
        end else if (commit && wr_ok) begin
            wr_pulse <= NUM_REGS'(1) << wr_idx;
        end else begin
            wr_pulse <= '0;
        end
    end

    // Write response: a new commit may overwrite a response completing on the same edge.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            BVALID <= 1'b0;
            BRESP  <= 2'b00;
        end else if (commit) begin
            BVALID <= 1'b1;
            BRESP  <= wr_ok ? OKAY : SLVERR;
        end else if (BREADY) begin
            BVALID <= 1'b0;
        end
    end

    // Read response sees register contents before any same-edge write.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= 2'b00;
        end else if (ARVALID && !RVALID) begin
            RVALID <= 1'b1;
            RDATA  <= rd_ok ? regs[rd_idx] : '0;
            RRESP  <= rd_ok ? OKAY : SLVERR;
        end else if (RREADY) begin
            RVALID <= 1'b0;
        end
    end

    for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_reg_q
        assign reg_q[32*k +: 32] = regs[k];
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave; B/R responses checked by a queue-based monitor.
module tb_axi4_lite_reg_slave;

    localparam int unsigned NR = 16;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  AWCACHE, ARCACHE, WSTRB;
    logic [2:0]  AWPROT, ARPROT;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [1:0]  BRESP, RRESP;
    logic [NR*32-1:0] reg_q;
    logic [NR-1:0]    wr_pulse;

    axi4_lite_reg_slave #(.NUM_REGS(NR), .RESET_VAL(32'h0000_0000)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARADDR(ARADDR), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    int total = 0;
    int bad   = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];
    logic [31:0] model [NR];
    int          exp_pulse [NR];
    int          seen_pulse [NR];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_regs(input string name);
        logic [NR*32-1:0] ev;
        for (int k = 0; k < int'(NR); k++) ev[32*k +: 32] = model[k];
        total++;
        if (reg_q !== ev) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, reg_q, ev);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? d[8*i +: 8] : o[8*i +: 8];
        return r;
    endfunction

    // Monitor: pop expectations whenever a response handshake is about to occur.
    always @(negedge ACLK) begin
        if (!ARESET && BVALID && BREADY) begin
            if (bq.size() == 0) chk("unexpected_b", 64'(BRESP), 64'hdead);
            else chk("bresp", 64'(BRESP), 64'(bq.pop_front()));
        end
        if (!ARESET && RVALID && RREADY) begin
            if (rq.size() == 0) chk("unexpected_r", {RDATA, RRESP}, 64'hdead);
            else chk("rdata_rresp", {RDATA, RRESP}, 64'(rq.pop_front()));
        end
        for (int k = 0; k < int'(NR); k++) if (wr_pulse[k]) seen_pulse[k]++;
    end

    task automatic send_aw(input logic [31:0] a);
        int n = 0;
        AWADDR = a; AWVALID = 1'b1;
        do begin @(negedge ACLK); n++; end while (!AWREADY && n < 100);
        if (!AWREADY) chk("aw_timeout", 0, 1);
        @(posedge ACLK); #1 AWVALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        WDATA = d; WSTRB = s; WVALID = 1'b1;
        do begin @(negedge ACLK); n++; end while (!WREADY && n < 100);
        if (!WREADY) chk("w_timeout", 0, 1);
        @(posedge ACLK); #1 WVALID = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n = 0;
        ARADDR = a; ARVALID = 1'b1;
        do begin @(negedge ACLK); n++; end while (!ARREADY && n < 100);
        if (!ARREADY) chk("ar_timeout", 0, 1);
        @(posedge ACLK); #1 ARVALID = 1'b0;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a < 32'(NR*4)) begin
            bq.push_back(2'b00);
            model[a[5:2]] = merge(model[a[5:2]], d, s);
            exp_pulse[a[5:2]]++;
        end else begin
            bq.push_back(2'b10);
        end
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic read(input logic [31:0] a);
        if (a < 32'(NR*4)) rq.push_back({model[a[5:2]], 2'b00});
        else rq.push_back({32'h0, 2'b10});
        send_ar(a);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin @(negedge ACLK); n++; end
        while ((BVALID || RVALID || bq.size() != 0 || rq.size() != 0) && n < 100);
        if (n >= 100) chk("idle_timeout", 0, 1);
        @(posedge ACLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESET = 1'b1; AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
        AWADDR = 0; WDATA = 0; WSTRB = 0; ARADDR = 0;
        AWCACHE = 0; ARCACHE = 0; AWPROT = 0; ARPROT = 0;
        for (int k = 0; k < int'(NR); k++) begin model[k] = 0; exp_pulse[k] = 0; seen_pulse[k] = 0; end
        #1;
        chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        chk("rst_valid", {BVALID, RVALID, BRESP, RRESP}, 6'b0);
        chk("rst_rdata", RDATA, 0);
        chk_regs("rst_regs");
        repeat (3) @(posedge ACLK);
        #1 ARESET = 1'b0;

        // 1: AW and W together, check commit latency and pulse width.
        @(posedge ACLK); #1;
        bq.push_back(2'b00); model[1] = 32'hDEADBEEF; exp_pulse[1]++;
        AWADDR = 32'h04; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        @(posedge ACLK); #1 AWVALID = 0; WVALID = 0;
        chk("t1_aw_full", AWREADY, 0);
        chk("t1_bvalid_early", BVALID, 0);
        @(posedge ACLK); #1;
        chk("t1_bvalid", BVALID, 1);
        chk_regs("t1_regs");
        chk("t1_pulse", wr_pulse, 16'h0002);
        @(posedge ACLK); #1;
        chk("t1_pulse_off", wr_pulse, 16'h0000);
        read(32'h04);
        wait_idle();

        // 2: W leads AW by 3 cycles, partial strobe.
        write(32'h08, 32'h11223344, 4'hF);
        wait_idle();
        bq.push_back(2'b00); model[2] = 32'h112233AA; exp_pulse[2]++;
        WDATA = 32'h000000AA; WSTRB = 4'h1; WVALID = 1;
        @(posedge ACLK); #1 WVALID = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_wready_held", WREADY, 0);
            @(posedge ACLK); #1;
        end
        send_aw(32'h08);
        chk("t2_wready_precommit", WREADY, 0);
        @(posedge ACLK); #1;
        chk("t2_wready_free", WREADY, 1);
        chk_regs("t2_regs");
        wait_idle();

        // 3: out-of-range window boundary.
        write(32'h40, 32'hFFFFFFFF, 4'hF);
        read(32'h40);
        wait_idle();
        chk_regs("t3_regs");

        // 4: B back-pressure with a second write queued behind it.
        BREADY = 0;
        write(32'h0C, 32'hCAFE0003, 4'hF);
        write(32'h44, 32'hFFFFFFFF, 4'hF);
        for (int i = 0; i < 5; i++) begin
            chk("t4_ready_stall", {AWREADY, WREADY}, 2'b00);
            chk("t4_b_stable", {BVALID, BRESP}, 3'b100);
            @(posedge ACLK); #1;
        end
        BREADY = 1;
        @(posedge ACLK); #1;
        chk("t4_b_b2b", {BVALID, BRESP}, 3'b110);
        wait_idle();
        chk_regs("t4_regs");

        // 5: R back-pressure, then AR and commit on one edge.
        RREADY = 0;
        read(32'h0C);
        for (int i = 0; i < 4; i++) begin
            chk("t5_arready", ARREADY, 0);
            chk("t5_r_stable", {RVALID, RDATA, RRESP}, {1'b1, 32'hCAFE0003, 2'b00});
            @(posedge ACLK); #1;
        end
        RREADY = 1;
        wait_idle();
        bq.push_back(2'b00); rq.push_back({32'hCAFE0003, 2'b00});
        AWADDR = 32'h0C; WDATA = 32'h00000055; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        @(posedge ACLK); #1 AWVALID = 0; WVALID = 0;
        ARADDR = 32'h0C; ARVALID = 1;
        @(posedge ACLK); #1 ARVALID = 0;
        model[3] = 32'h00000055; exp_pulse[3]++;
        wait_idle();
        chk_regs("t5_regs");

        // 6: reset during an outstanding B with AW held and W pending.
        BREADY = 0;
        exp_pulse[6]++;
        fork
            send_aw(32'h18);
            send_w(32'h00000077, 4'hF);
        join
        send_aw(32'h14);
        AWADDR = 32'h1C; AWVALID = 1;
        @(posedge ACLK); #1;
        chk("t6_aw_stall", AWREADY, 0);
        chk("t6_b_pending", BVALID, 1);
        ARESET = 1;
        #1;
        for (int k = 0; k < int'(NR); k++) model[k] = 0;
        chk("t6_rst_b", BVALID, 0);
        chk("t6_rst_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
        chk("t6_rst_pulse", wr_pulse, 0);
        chk_regs("t6_rst_regs");
        AWVALID = 0;
        repeat (2) @(posedge ACLK);
        #1 ARESET = 0; BREADY = 1;
        repeat (3) @(posedge ACLK);
        #1 chk("t6_no_stale_b", BVALID, 0);
        write(32'h14, 32'hAB001234, 4'b0011);
        wait_idle();
        read(32'h14);
        wait_idle();
        chk_regs("t6_regs");

        for (int k = 0; k < int'(NR); k++) chk($sformatf("pulse_count_%0d", k), seen_pulse[k], exp_pulse[k]);
        chk("queues_drained", bq.size() + rq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
